// File: rtl/mem_io_pkg.sv
// Shared constants, scan states and the 7-segment glyph table
// for the store-side memory/IO path.
package mem_io_pkg;

  localparam logic [31:0] ADDR_LED  = 32'd252;
  localparam logic [31:0] ADDR_DISP = 32'd253;
  localparam logic [31:0] ADDR_SW   = 32'd254;
  localparam logic [31:0] ADDR_BTN  = 32'd255;

  typedef enum logic [1:0] {
    DIG0,
    DIG1,
    DIG2,
    DIG3
  } scan_state_t;

  // active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg7(input logic [3:0] n);
    return SEG7_TABLE[n];
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed driver for a 4-digit active-low
// 7-segment display.
module seg7_scan
  import mem_io_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] disp,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  scan_state_t state;
  scan_state_t state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] nib;
  logic [3:0] an_nx;

  always_comb begin
    state_nx = state;
    if (cnt == TC) begin
      unique case (state)
        DIG0: state_nx = DIG1;
        DIG1: state_nx = DIG2;
        DIG2: state_nx = DIG3;
        DIG3: state_nx = DIG0;
      endcase
    end
  end

  // decode from the next state so an and seg move together
  always_comb begin
    nib   = disp[3:0];
    an_nx = 4'b1110;
    unique case (state_nx)
      DIG0: begin nib = disp[3:0];   an_nx = 4'b1110; end
      DIG1: begin nib = disp[7:4];   an_nx = 4'b1101; end
      DIG2: begin nib = disp[11:8];  an_nx = 4'b1011; end
      DIG3: begin nib = disp[15:12]; an_nx = 4'b0111; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIG0;
      cnt   <= '0;
      an    <= 4'b1110;
      seg   <= SEG7_TABLE[0];
    end else begin
      cnt   <= (cnt == TC) ? '0 : cnt + 1'b1;
      state <= state_nx;
      an    <= an_nx;
      seg   <= seg7(nib);
    end
  end

endmodule

// File: rtl/mem_write_io.sv
// Store decode: RAM write port, LED and display registers,
// ack/err pulses and the display scanner.
module mem_write_io
  import mem_io_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int RAM_WORDS   = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        ram_we,
  output logic [5:0]  ram_addr,
  output logic [31:0] ram_wd,
  output logic [7:0]  leds,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        wr_ack,
  output logic        wr_err
);

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS * 4);

  logic        is_ram;
  logic        is_led;
  logic        is_disp;
  logic [15:0] disp;

  assign is_ram  = (a < RAM_LIMIT);
  assign is_led  = (a == ADDR_LED);
  assign is_disp = (a == ADDR_DISP);

  // switch/button and unmapped addresses fall to the error arm
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_wd   <= '0;
      leds     <= '0;
      disp     <= '0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (we) begin
        unique case (1'b1)
          is_ram: begin
            ram_we   <= 1'b1;
            ram_addr <= a[7:2];
            ram_wd   <= wd;
            wr_ack   <= 1'b1;
          end
          is_led: begin
            leds   <= wd[7:0];
            wr_ack <= 1'b1;
          end
          is_disp: begin
            disp   <= wd[15:0];
            wr_ack <= 1'b1;
          end
          default: wr_err <= 1'b1;
        endcase
      end
    end
  end

  seg7_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .disp (disp),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_mem_write_io.sv
// Randomized and directed bench for mem_write_io against
// a cycle-count based reference model.
module tb_mem_write_io;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [31:0] ram_wd;
  logic [7:0]  leds;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        wr_ack;
  logic        wr_err;

  mem_write_io #(
    .REFRESH_DIV(DIV),
    .RAM_WORDS  (63)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .a       (a),
    .wd      (wd),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_wd  (ram_wd),
    .leds    (leds),
    .seg     (seg),
    .an      (an),
    .wr_ack  (wr_ack),
    .wr_err  (wr_err)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int errors = 0;
  int checks = 0;

  int          k;
  logic        m_ram_we;
  logic [5:0]  m_ram_addr;
  logic [31:0] m_ram_wd;
  logic [7:0]  m_leds;
  logic [15:0] m_disp;
  logic        m_ack;
  logic        m_err;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_ram_we = 0; m_ram_addr = 0; m_ram_wd = 0;
    m_leds = 0; m_disp = 0; m_ack = 0; m_err = 0;
    m_seg = glyph[0]; m_an = 4'b1110;
  endtask

  task automatic check_all();
    chk("ram_we", ram_we, m_ram_we);
    chk("ram_addr", ram_addr, m_ram_addr);
    chk("ram_wd", ram_wd, m_ram_wd);
    chk("leds", leds, m_leds);
    chk("wr_ack", wr_ack, m_ack);
    chk("wr_err", wr_err, m_err);
    chk("an", an, m_an);
    chk("seg", seg, m_seg);
  endtask

  task automatic step(input logic w, input logic [31:0] addr,
                      input logic [31:0] data);
    int dig;
    we = w; a = addr; wd = data;
    @(posedge clk);
    #1;
    k++;
    dig = (k / DIV) % 4;
    m_an = ~(4'b0001 << dig);
    // seg reflects the display value held before this edge
    m_seg = glyph[(m_disp >> (4 * dig)) & 16'hF];
    m_ram_we = 0; m_ack = 0; m_err = 0;
    if (w) begin
      if (addr < 252) begin
        m_ram_we = 1; m_ram_addr = addr[7:2];
        m_ram_wd = data; m_ack = 1;
      end else if (addr == 252) begin
        m_leds = data[7:0]; m_ack = 1;
      end else if (addr == 253) begin
        m_disp = data[15:0]; m_ack = 1;
      end else begin
        m_err = 1;
      end
    end
    check_all();
    we = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = $urandom_range(0, 5);
    case (sel)
      0, 1: return $urandom_range(0, 251);
      2: return 32'd252;
      3: return 32'd253;
      4: return 32'(254 + $urandom_range(0, 1));
      default: return 32'd256 + $urandom();
    endcase
  endfunction

  initial begin
    @(negedge clk);
    do_reset();

    // idle scan: four digits, then wrap
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("an_dig1", an, 4'b1101);
    for (int i = 0; i < 12; i++) step(0, 0, 0);
    chk("an_wrap", an, 4'b1110);

    step(1, 32'd8, 32'hDEADBEEF);
    chk("ram_addr_8", ram_addr, 6'd2);
    step(0, 0, 0);

    step(1, 32'd252, 32'h123456A5);
    chk("leds_a5", leds, 8'hA5);
    step(1, 32'd254, 32'hFF);
    chk("leds_hold", leds, 8'hA5);

    do_reset();
    step(1, 32'd253, 32'h0000C3F1);
    step(0, 0, 0);
    chk("seg_1", seg, 7'b1111001);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("seg_f", seg, 7'b0001110);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("seg_3", seg, 7'b0110000);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("seg_c", seg, 7'b1000110);

    // back-to-back RAM, LED, unmapped
    step(1, 32'd0, 32'h11111111);
    step(1, 32'd252, 32'h3C);
    step(1, 32'd300, 32'h0);
    step(0, 0, 0);

    // async reset at DIG2/count 2 right after a RAM store
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    step(1, 32'd252, 32'h5A);
    step(1, 32'd16, 32'hCAFEF00D);
    chk("pre_rst_an", an, 4'b1011);
    #2;
    rst_n = 0;
    #1;
    chk("async_an", an, 4'b1110);
    chk("async_ram_we", ram_we, 1'b0);
    chk("async_leds", leds, 8'h00);
    do_reset();

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), $urandom());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
